bit_vector_fifo: RTL

- Bit-serial to vector FIFO. Accepts one input bit per cycle and assembles bits into VEC_W-bit vectors.
- Completed vectors are stored in a DEPTH-entry ring buffer and served on request with a registered output.
- Generalised successor of the team's fixed 8-bit vector buffer. Adds:
  - parametrised vector width, depth and bit order;
  - input back-pressure (bit_ready);
  - full/empty/level status;
  - a flush that commits a partial vector;
  - a sticky overflow flag.

---
 rtl/bit_vector_fifo_pkg.sv | 9 +
 rtl/bit_vector_fifo_if.sv | 31 +++
 rtl/bit_vector_fifo_deser.sv | 60 ++++++
 rtl/bit_vector_fifo.sv | 112 +++++++++++
 4 files changed

// File: rtl/bit_vector_fifo_pkg.sv
// Shared helpers for the bit-serial to vector FIFO.
package bit_vector_fifo_pkg;

  // Pointer/counter width for n entries; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_vector_fifo_if.sv
// Producer/consumer bus of the bit-serial to vector FIFO.
interface bit_vector_fifo_if
  import bit_vector_fifo_pkg::*;
#(
  parameter int VEC_W = 8,
  parameter int DEPTH = 8
);
  localparam int LW = ptr_w(DEPTH) + 1;

  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             flush;
  logic             req;
  logic [VEC_W-1:0] vector;
  logic             valid;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic             overflow;

  modport master (
    output bit_in, bit_valid, flush, req,
    input  bit_ready, vector, valid, full, empty, level, overflow
  );

  modport slave (
    input  bit_in, bit_valid, flush, req,
    output bit_ready, vector, valid, full, empty, level, overflow
  );
endinterface

// File: rtl/bit_vector_fifo_deser.sv
// Bit deserializer: shift register plus fill counter. Exposes the assembled
// value including the bit accepted this cycle, and the same value zero-aligned
// for committing a partial vector.
module bit_deserializer
  import bit_vector_fifo_pkg::*;
#(
  parameter int VEC_W     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = ptr_w(VEC_W)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             accept,
  input  logic             commit_partial,
  output logic [VEC_W-1:0] shreg,
  output logic [CW-1:0]    fill,
  output logic             done,
  output logic [VEC_W-1:0] flush_vec
);
  typedef logic [VEC_W-1:0] vec_t;
  localparam int NW = CW + 1;

  vec_t          shreg_q, shreg_d, shifted;
  logic [CW-1:0] fill_q, fill_d;
  logic [NW-1:0] cnt, shamt;

  // Shift-in, live value, alignment of a partial vector and next state.
  always_comb begin
    shifted   = MSB_FIRST ? {shreg_q[VEC_W-2:0], bit_in} : {bit_in, shreg_q[VEC_W-1:1]};
    shreg     = accept ? shifted : shreg_q;
    cnt       = {1'b0, fill_q} + NW'(accept);
    // Padding with zeros equals shifting the missing bits in as zeros.
    shamt     = NW'(VEC_W) - cnt;
    flush_vec = MSB_FIRST ? (shreg << shamt) : (shreg >> shamt);
    done      = accept && (fill_q == CW'(VEC_W - 1));
    fill_d    = fill_q;
    shreg_d   = shreg_q;
    if (done || commit_partial) begin
      fill_d  = '0;
      shreg_d = '0;
    end else if (accept) begin
      fill_d  = fill_q + CW'(1);
      shreg_d = shifted;
    end
  end

  // Assembly state; reset discards any partial vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      fill_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
    end
  end

  assign fill = fill_q;
endmodule

// File: rtl/bit_vector_fifo.sv
// Bit-serial to vector FIFO: deserializer feeding a DEPTH-entry ring buffer
// with registered single-cycle read, flush of partial vectors and a sticky
// overflow flag.
module bit_vector_fifo
  import bit_vector_fifo_pkg::*;
#(
  parameter int VEC_W     = 8,
  parameter int DEPTH     = 8,
  parameter bit MSB_FIRST = 1'b1
)(
  input  logic               clk,
  input  logic               rst_n,
  bit_vector_fifo_if.slave   bus
);
  typedef logic [VEC_W-1:0] vec_t;
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = ptr_w(VEC_W);

  logic [PW-1:0]             prod_q, prod_d, cons_q, cons_d;
  logic [LW-1:0]             level_q, level_d;
  logic                      flush_pend_q, flush_pend_d;
  vec_t                      vector_q, vector_d;
  logic                      valid_q, valid_d;
  logic                      overflow_q, overflow_d;
  logic [DEPTH-1:0][VEC_W-1:0] mem_q, mem_d;

  logic          full, empty, bit_ready, accept, commit_fl, push, pop;
  vec_t          live_vec, flush_vec, push_vec;
  logic [CW-1:0] fill;
  logic          done;

  bit_deserializer #(
    .VEC_W     (VEC_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_deser (
    .clk            (clk),
    .rst_n          (rst_n),
    .bit_in         (bus.bit_in),
    .accept         (accept),
    .commit_partial (commit_fl),
    .shreg          (live_vec),
    .fill           (fill),
    .done           (done),
    .flush_vec      (flush_vec)
  );

  // Status decodes from registered state; handshake and push/pop qualifiers.
  always_comb begin
    full      = (level_q == LW'(DEPTH));
    empty     = (level_q == '0);
    // Only the bit that would complete a vector is refused while full.
    bit_ready = !(full && (fill == CW'(VEC_W - 1)));
    accept    = bus.bit_valid && bit_ready;
    commit_fl = flush_pend_q && (fill != '0) && !full;
    push      = done || commit_fl;
    push_vec  = commit_fl ? flush_vec : live_vec;
    pop       = bus.req && !empty;
  end

  // Next state for pointers, level, flush request, read port and overflow.
  always_comb begin
    prod_d       = push ? prod_q + PW'(1) : prod_q;
    cons_d       = pop  ? cons_q + PW'(1) : cons_q;
    level_d      = level_q + LW'(push) - LW'(pop);
    // A pending flush with nothing assembled simply lapses.
    flush_pend_d = bus.flush || (flush_pend_q && !((fill == '0) || commit_fl));
    vector_d     = pop ? mem_q[cons_q] : '0;
    valid_d      = pop;
    overflow_d   = overflow_q || (bus.bit_valid && !bit_ready);
  end

  // Ring buffer write port.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[prod_q] = push_vec;
  end

  // Control state with async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q       <= '0;
      cons_q       <= '0;
      level_q      <= '0;
      flush_pend_q <= 1'b0;
      vector_q     <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      prod_q       <= prod_d;
      cons_q       <= cons_d;
      level_q      <= level_d;
      flush_pend_q <= flush_pend_d;
      vector_q     <= vector_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Buffer storage carries no reset; contents are qualified by level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.bit_ready = bit_ready;
  assign bus.vector    = vector_q;
  assign bus.valid     = valid_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
endmodule
